iir_out_writer: RTL and testbench
=================================

// Module: iir_out_writer
// PURPOSE
// - Downstream stage of the IIR filter: accepts filtered samples (Yn) on a valid/ready link,
//   buffers them in a small FIFO and writes them to output memory (WEN/WAddr/Wdata).
// - Absorbs output-memory stalls (mem_busy) without dropping samples; raises Finish once the
//   filter signals data_done and every accepted sample has been written.
// PARAMETERS
// - DEPTH  4   FIFO entries, power of two, >= 2
// - AW     20  output address width
// - BASE   0   first write address
// PORTS
// - clk        in   1   rising-edge clock
// - rst        in   1   asynchronous reset, active-low
// - y_valid    in   1   filter sample valid
// - y_data     in   16  filter sample Yn, two's complement
// - data_done  in   1   upstream end-of-stream, pulse or level
// - mem_busy   in   1   output memory cannot take a write this cycle
// - y_ready    out  1   FIFO can accept a sample
// - WEN        out  1   write strobe, registered
// - WAddr      out  AW  write address, registered
// - Wdata      out  16  write data, registered
// - Finish     out  1   stream fully written, sticky
// - peak       out  16  max |Wdata| written (present only with IIR_WR_PEAK_EN)
// BEHAVIOUR
// - Reset (rst=0, async): WEN=0, WAddr=BASE, Wdata=0, Finish=0, peak=0, FIFO empty, state=IDLE.
// - FSM: IDLE -(first accept)-> RUN; IDLE/RUN -(data_done=1)-> DRAIN; DRAIN -(FIFO empty,
//   no write pending)-> DONE. DONE is terminal until reset.
// - y_ready = (count < DEPTH) && state in {IDLE,RUN}; combinational from registered state.
// - Accept = y_valid && y_ready. data_done in the same cycle as an accept: sample is kept and
//   is the last one; no accepts after that edge.
// - Write issue, each cycle: if count>0 && !mem_busy && state!=DONE: pop head; next edge
//   WEN=1, Wdata=head, WAddr=wptr; wptr++ afterwards. Else next edge WEN=0; WAddr/Wdata hold.
// - Latency: sample accepted at edge N into empty FIFO -> WEN=1 with that data from edge N+1.
// - No bypass: push and pop of the same entry never happen in one cycle; push+pop of different
//   entries does, count unchanged. Full FIFO: y_ready=0, upstream must hold y_valid/y_data.
// - Order strictly preserved; sample k written to BASE+k mod 2^AW (wraps silently to 0).
// - Finish: set on the edge after the last WEN=1 of DRAIN (or one edge after entering DRAIN
//   with empty FIFO); held until reset.
// - Reset mid-stream: FIFO contents discarded, address restarts at BASE, no partial write.
// CONFIGURATION
// - IIR_WR_PEAK_EN defined: peak port exists; on each write peak <= max(peak, |Wdata|),
//   |0x8000| saturates to 0x7FFF; updates the same edge WEN rises; cleared only by reset.
// - Undefined: no peak port, no peak logic; all other behaviour identical.
// TESTING
// - Reset: rst=0 mid-stream with 3 queued -> WEN=0, WAddr=BASE, Finish=0, y_ready=1 immediately.
// - Stream 0x0001,0x8000,0x7FFF back-to-back, mem_busy=0 -> WEN=1 3 cycles starting one edge
//   after first accept, WAddr 0,1,2, Wdata in order.
// - mem_busy=1, offer 5 samples, DEPTH=4 -> y_ready=0 after 4 accepts, WEN=0; release
//   mem_busy -> 5 writes, addresses 0..4, data in order, nothing lost.
// - data_done with 2 queued -> y_ready=0 same cycle, 2 writes, Finish=1 edge after last WEN,
//   stays 1; data_done in IDLE -> zero writes, Finish=1 within 2 cycles.
// - AW=4, BASE=14, 4 samples -> WAddr 14,15,0,1.
// - IIR_WR_PEAK_EN: samples 0x0010,0xFF00,0x8000 -> peak 0x0010,0x0100,0x7FFF.

Source files
------------

// File: rtl/iir_out_writer_if.sv
// Sample-in and memory-write link of the IIR output writer.
interface iir_out_writer_if #(
    parameter int unsigned AW = 20
);
    logic          y_valid;
    logic [15:0]   y_data;
    logic          y_ready;
    logic          data_done;
    logic          mem_busy;
    logic          WEN;
    logic [AW-1:0] WAddr;
    logic [15:0]   Wdata;
    logic          Finish;

    modport master (
        output y_valid, y_data, data_done, mem_busy,
        input  y_ready, WEN, WAddr, Wdata, Finish
    );
    modport slave (
        input  y_valid, y_data, data_done, mem_busy,
        output y_ready, WEN, WAddr, Wdata, Finish
    );
endinterface

// File: rtl/iir_out_writer.sv
// IIR output stage: FIFO-buffers filtered samples and writes them to output memory.
// Optional macro IIR_WR_PEAK_EN adds a peak |Wdata| tracker on the peak port.
module iir_out_writer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 20,
    parameter int unsigned BASE  = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IIR_WR_PEAK_EN
    output logic [15:0] peak,
`endif
    iir_out_writer_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] addr;
    logic [DW-1:0] head;
    logic          ready;
    logic          accept;
    logic          pop;

    assign head        = mem[rd_ptr];
    assign bus.y_ready = ready;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // next state; data_done is ignored once draining
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.data_done) state_nx = DRAIN;
                     else if (accept)   state_nx = RUN;
            RUN:     if (bus.data_done) state_nx = DRAIN;
            DRAIN:   if (count == '0)   state_nx = DONE;
            default: state_nx = DONE;
        endcase
    end

    // handshake and pop decode; pop uses registered count so a fresh entry is never bypassed
    always_comb begin
        ready  = 1'b0;
        accept = 1'b0;
        pop    = 1'b0;
        ready  = (count < CW'(DEPTH)) && ((state == IDLE) || (state == RUN));
        accept = bus.y_valid && ready;
        pop    = (count != '0) && !bus.mem_busy && (state != DONE);
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.y_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // memory write port; address wraps modulo 2^AW
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.WEN   <= 1'b0;
            bus.WAddr <= AW'(BASE);
            bus.Wdata <= '0;
            addr      <= AW'(BASE);
        end else begin
            bus.WEN <= pop;
            if (pop) begin
                bus.WAddr <= addr;
                bus.Wdata <= head;
                addr      <= addr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                    bus.Finish <= 1'b0;
        else if ((state == DRAIN) && (count == '0))  bus.Finish <= 1'b1;
    end

`ifdef IIR_WR_PEAK_EN
    logic [DW-1:0] mag;

    // magnitude with the most-negative code saturated
    always_comb begin
        mag = head;
        if (head[DW-1]) begin
            if (head == {1'b1, {(DW-1){1'b0}}}) mag = {1'b0, {(DW-1){1'b1}}};
            else                                mag = DW'(~head + DW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                     peak <= '0;
        else if (pop && (mag > peak)) peak <= mag;
    end
`endif
endmodule

// File: tb/tb_iir_out_writer.sv
// Directed scoreboard bench for iir_out_writer (define IIR_WR_PEAK_EN to cover peak).
`timescale 1ns/1ps
module tb_iir_out_writer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iir_out_writer_if #(.AW(20)) ifa ();
    iir_out_writer_if #(.AW(4))  ifb ();
`ifdef IIR_WR_PEAK_EN
    logic [15:0] peak_a;
    logic [15:0] peak_b;
`endif

    iir_out_writer #(.DEPTH(4), .AW(20), .BASE(0)) dut_a (
        .clk(clk), .rst(rst),
`ifdef IIR_WR_PEAK_EN
        .peak(peak_a),
`endif
        .bus(ifa)
    );
    iir_out_writer #(.DEPTH(4), .AW(4), .BASE(14)) dut_b (
        .clk(clk), .rst(rst),
`ifdef IIR_WR_PEAK_EN
        .peak(peak_b),
`endif
        .bus(ifb)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    int          nb_b  = 0;
    logic [35:0] exp_q [$];
    logic [35:0] exp_w;
    logic [19:0] exp_addr;
    logic [15:0] exp_peak;
    logic [3:0]  b_addr [4];
    logic [15:0] b_data [4];
    logic [3:0]  exp_b_addr [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard for dut_a writes
    always @(negedge clk) begin
        if (rst === 1'b1 && ifa.WEN === 1'b1) begin
            n_wr++;
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                chk("wr_addr", 32'(ifa.WAddr), 32'(exp_w[35:16]));
                chk("wr_data", 32'(ifa.Wdata), 32'(exp_w[15:0]));
`ifdef IIR_WR_PEAK_EN
                begin
                    logic [15:0] d;
                    logic [15:0] m;
                    d = exp_w[15:0];
                    if (!d[15])            m = d;
                    else if (d == 16'h8000) m = 16'h7FFF;
                    else                   m = 16'(16'd0 - d);
                    if (m > exp_peak) exp_peak = m;
                    chk("peak", 32'(peak_a), 32'(exp_peak));
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1 && ifb.WEN === 1'b1) begin
            if (nb_b < 4) begin
                b_addr[nb_b] = ifb.WAddr;
                b_data[nb_b] = ifb.Wdata;
            end
            nb_b++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [15:0] d, input logic done);
        int guard;
        guard         = 0;
        ifa.y_valid   = 1'b1;
        ifa.y_data    = d;
        ifa.data_done = done;
        while (ifa.y_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("send_ready", 32'(guard < 100), 32'd1);
        exp_q.push_back({exp_addr, d});
        exp_addr = exp_addr + 20'd1;
        @(negedge clk);
        ifa.y_valid   = 1'b0;
        ifa.data_done = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        ifa.y_valid   = 1'b0;
        ifa.data_done = 1'b0;
        ifa.mem_busy  = 1'b0;
        exp_q.delete();
        exp_addr = 20'd0;
        exp_peak = 16'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int last;
        int fin_c;
        rst           = 1'b0;
        ifa.y_valid   = 1'b0;
        ifa.y_data    = 16'd0;
        ifa.data_done = 1'b0;
        ifa.mem_busy  = 1'b0;
        ifb.y_valid   = 1'b0;
        ifb.y_data    = 16'd0;
        ifb.data_done = 1'b0;
        ifb.mem_busy  = 1'b0;
        exp_addr      = 20'd0;
        exp_peak      = 16'd0;
        exp_b_addr[0] = 4'd14;
        exp_b_addr[1] = 4'd15;
        exp_b_addr[2] = 4'd0;
        exp_b_addr[3] = 4'd1;
        repeat (3) @(negedge clk);

        // reset values
        chk("rst_wen",    32'(ifa.WEN),     32'd0);
        chk("rst_waddr",  32'(ifa.WAddr),   32'd0);
        chk("rst_wdata",  32'(ifa.Wdata),   32'd0);
        chk("rst_finish", 32'(ifa.Finish),  32'd0);
        chk("rst_ready",  32'(ifa.y_ready), 32'd1);
        chk("rst_b_addr", 32'(ifb.WAddr),   32'd14);
        rst = 1'b1;
        @(negedge clk);

        // back-to-back stream, one-edge latency
        w0 = n_wr;
        send(16'h0001, 1'b0);
        chk("lat_wen_before", 32'(ifa.WEN), 32'd0);
        send(16'h8000, 1'b0);
        chk("lat_wen_first",  32'(ifa.WEN),   32'd1);
        chk("lat_data_first", 32'(ifa.Wdata), 32'h0001);
        send(16'h7FFF, 1'b0);
        chk("b2b_wen", 32'(ifa.WEN), 32'd1);
        wait_empty("stream_drain");
        chk("stream_writes", 32'(n_wr - w0), 32'd3);

        // memory stall fills FIFO, nothing lost
        do_reset();
        w0 = n_wr;
        ifa.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 1'b0);
        ifa.y_valid = 1'b1;
        ifa.y_data  = 16'h0104;
        chk("full_ready", 32'(ifa.y_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("full_ready_hold", 32'(ifa.y_ready), 32'd0);
        chk("busy_wen",        32'(ifa.WEN),     32'd0);
        chk("busy_no_writes",  32'(n_wr - w0),   32'd0);
        ifa.mem_busy = 1'b0;
        send(16'h0104, 1'b0);
        wait_empty("busy_drain");
        chk("busy_writes", 32'(n_wr - w0), 32'd5);

        // data_done with two samples queued
        do_reset();
        w0 = n_wr;
        ifa.mem_busy = 1'b1;
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        ifa.data_done = 1'b1;
        @(negedge clk);
        ifa.data_done = 1'b0;
        chk("done_ready", 32'(ifa.y_ready), 32'd0);
        ifa.y_valid  = 1'b1;
        ifa.y_data   = 16'h3333;
        ifa.mem_busy = 1'b0;
        last  = -1;
        fin_c = -1;
        for (int c = 0; c < 20 && fin_c < 0; c++) begin
            @(negedge clk);
            if (ifa.Finish === 1'b1) fin_c = c;
            else if (ifa.WEN === 1'b1) last = c;
        end
        chk("done_finish_seen",   32'(fin_c >= 0), 32'd1);
        chk("done_finish_timing", 32'(fin_c),      32'(last + 1));
        repeat (5) @(negedge clk);
        ifa.y_valid = 1'b0;
        chk("done_finish_sticky", 32'(ifa.Finish), 32'd1);
        chk("done_writes",        32'(n_wr - w0),  32'd2);

        // data_done on the same edge as the last accept
        do_reset();
        w0 = n_wr;
        send(16'h0A0A, 1'b0);
        send(16'h0B0B, 1'b1);
        chk("last_ready", 32'(ifa.y_ready), 32'd0);
        wait_empty("last_drain");
        repeat (2) @(negedge clk);
        chk("last_finish", 32'(ifa.Finish), 32'd1);
        chk("last_writes", 32'(n_wr - w0),  32'd2);

        // data_done while idle
        do_reset();
        w0 = n_wr;
        ifa.data_done = 1'b1;
        @(negedge clk);
        ifa.data_done = 1'b0;
        chk("idle_done_fin0", 32'(ifa.Finish), 32'd0);
        @(negedge clk);
        chk("idle_done_fin1",  32'(ifa.Finish),  32'd1);
        chk("idle_done_ready", 32'(ifa.y_ready), 32'd0);
        chk("idle_done_wr",    32'(n_wr - w0),   32'd0);

        // address wrap on the AW=4, BASE=14 instance
        ifb.y_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifb.y_data = 16'hB000 + 16'(i);
            @(negedge clk);
        end
        ifb.y_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("wrap_writes", 32'(nb_b), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", 32'(b_addr[i]), 32'(exp_b_addr[i]));
            chk("wrap_data", 32'(b_data[i]), 32'(16'hB000 + 16'(i)));
        end
`ifdef IIR_WR_PEAK_EN
        chk("wrap_peak", 32'(peak_b), 32'h5000);

        // peak tracking with saturation of 0x8000
        do_reset();
        chk("peak_rst", 32'(peak_a), 32'd0);
        send(16'h0010, 1'b0);
        send(16'hFF00, 1'b0);
        send(16'h8000, 1'b0);
        wait_empty("peak_drain");
        chk("peak_final", 32'(peak_a), 32'h7FFF);
`endif

        // reset mid-stream with three queued
        do_reset();
        send(16'h0C01, 1'b0);
        send(16'h0C02, 1'b0);
        wait_empty("mid_pre_drain");
        ifa.mem_busy = 1'b1;
        send(16'h0C03, 1'b0);
        send(16'h0C04, 1'b0);
        send(16'h0C05, 1'b0);
        #2;
        rst = 1'b0;
        exp_q.delete();
        exp_addr = 20'd0;
        exp_peak = 16'd0;
        #1;
        chk("mid_rst_wen",    32'(ifa.WEN),     32'd0);
        chk("mid_rst_waddr",  32'(ifa.WAddr),   32'd0);
        chk("mid_rst_finish", 32'(ifa.Finish),  32'd0);
        chk("mid_rst_ready",  32'(ifa.y_ready), 32'd1);
        @(negedge clk);
        rst          = 1'b1;
        ifa.mem_busy = 1'b0;
        w0 = n_wr;
        repeat (4) @(negedge clk);
        chk("mid_rst_discard", 32'(n_wr - w0), 32'd0);
        send(16'h5A5A, 1'b0);
        wait_empty("mid_rst_restart");
        chk("mid_rst_writes", 32'(n_wr - w0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
